// File: rtl/integral_image_builder_if.sv
// ============================================================================
// Module      : integral_image_builder_if
// Description : Pixel stream, frame status and classifier read bus of the
//               integral image builder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface integral_image_builder_if #(
    parameter int PIX_W  = 4,
    parameter int DATA_W = 21,
    parameter int ADDR_W = 15
);
    logic                     sof;
    logic                     pix_valid;
    logic [PIX_W-1:0]         pix_data;
    logic                     frame_ready;
    logic                     frame_done;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;

    // master: pixel source plus classifier; slave: the builder
    modport master (
        output sof, pix_valid, pix_data, rd_addr,
        input  frame_ready, frame_done, rd_data
    );

    modport slave (
        input  sof, pix_valid, pix_data, rd_addr,
        output frame_ready, frame_done, rd_data
    );
endinterface

`default_nettype wire

// File: rtl/integral_image_builder.sv
// ============================================================================
// Module      : integral_image_builder
// Description : Builds a raster-order integral image into on-chip RAM and
//               serves fixed 3-cycle-latency random reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module integral_image_builder #(
    parameter int II_WIDTH  = 160,
    parameter int II_HEIGHT = 120,
    parameter int PIX_W     = 4,
    parameter int DATA_W    = 21,
    parameter int ADDR_W    = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    integral_image_builder_if.slave   bus
);

    localparam int c_depth = II_WIDTH * II_HEIGHT;
    localparam int c_x_w   = $clog2(II_WIDTH);
    localparam int c_y_w   = $clog2(II_HEIGHT);
    localparam int c_acc_w = $clog2(II_WIDTH * ((2 ** PIX_W) - 1) + 1);

    localparam logic [c_x_w-1:0]  c_last_x  = c_x_w'(II_WIDTH - 1);
    localparam logic [c_y_w-1:0]  c_last_y  = c_y_w'(II_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] c_depth_a = ADDR_W'(c_depth);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_frame_ready;

    logic [c_x_w-1:0]   r_x;
    logic [c_y_w-1:0]   r_y;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [c_acc_w-1:0] r_row_acc;
    logic               r_frame_done;

    logic [DATA_W-1:0]  r_line_buf [0:II_WIDTH-1];
    logic [DATA_W-1:0]  r_mem      [0:c_depth-1];

    logic                     w_start;
    logic                     w_accept;
    logic                     w_last;
    logic [c_x_w-1:0]         w_x;
    logic [c_y_w-1:0]         w_y;
    logic [ADDR_W-1:0]        w_wr_addr;
    logic [c_acc_w-1:0]       w_row_acc_nxt;
    logic [DATA_W-1:0]        w_above;
    logic [DATA_W-1:0]        w_ii;

    logic                     w_rd_in_range;
    logic [ADDR_W-1:0]        r_rd_addr;
    logic                     r_rd_ok1;
    logic                     r_rd_ok2;
    logic [DATA_W-1:0]        r_rd_word;
    logic signed [DATA_W-1:0] r_rd_data;

    // A start-of-frame pixel is always position (0,0), whatever the state.
    assign w_start   = bus.sof && bus.pix_valid;
    assign w_accept  = bus.pix_valid && (bus.sof || (r_state == FILL));
    assign w_x       = w_start ? '0 : r_x;
    assign w_y       = w_start ? '0 : r_y;
    assign w_wr_addr = w_start ? '0 : r_wr_addr;
    assign w_last    = w_accept && (w_x == c_last_x) && (w_y == c_last_y);

    assign w_row_acc_nxt = ((w_x == '0) ? '0 : r_row_acc) + c_acc_w'(bus.pix_data);
    assign w_above       = (w_y == '0) ? '0 : r_line_buf[w_x];
    assign w_ii          = DATA_W'(w_row_acc_nxt) + w_above;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_frame_ready = 1'b1;
                if (w_start) begin
                    w_state_nxt = FILL;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_wr_addr    <= '0;
            r_row_acc    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_accept) begin
                r_row_acc <= w_row_acc_nxt;
                r_wr_addr <= w_wr_addr + 1'b1;
                if (w_x == c_last_x) begin
                    r_x <= '0;
                    r_y <= w_y + 1'b1;
                end else begin
                    r_x <= w_x + 1'b1;
                    r_y <= w_y;
                end
            end
        end
    end

    // Storage is never reset; the read port sees pre-write contents on a collision.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line_buf[w_x]  <= w_ii;
            r_mem[w_wr_addr] <= w_ii;
        end
        r_rd_word <= r_mem[r_rd_addr];
    end

    assign w_rd_in_range = (bus.rd_addr < c_depth_a);

    // Out-of-range addresses read location 0 and are masked on the way out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_rd_ok1  <= 1'b0;
            r_rd_ok2  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_addr <= w_rd_in_range ? bus.rd_addr : '0;
            r_rd_ok1  <= w_rd_in_range;
            r_rd_ok2  <= r_rd_ok1;
            r_rd_data <= r_rd_ok2 ? $signed(r_rd_word) : '0;
        end
    end

    assign bus.frame_ready = w_frame_ready;
    assign bus.frame_done  = r_frame_done;
    assign bus.rd_data     = r_rd_data;

endmodule

`default_nettype wire

// File: doc/integral_image_builder.md
Name: integral_image_builder

Overview:
- Builds a 160x120 integral image from a raster-order stream of 4-bit grayscale pixels and stores it in on-chip RAM.
- Serves random-access reads from the classifier: the classifier drives an address, and the block returns the 21-bit signed integral value exactly 3 clk cycles later.
- Sits between the camera/grayscale pipeline (write side) and the detection state machine and classifier (read side).
- Signals when a complete frame is available.

Parameters:
- II_WIDTH, 160, image width in pixels.
- II_HEIGHT, 120, image height in pixels.
- PIX_W, 4, pixel width in bits.
- DATA_W, 21, integral value width, signed. Maximum value 160*120*15 = 288000 fits.
- ADDR_W, 15, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sof  in  1  start of frame; qualifies the first pixel of a frame together with pix_valid.
- pix_valid  in  1  pix_data is valid this cycle.
- pix_data  in  PIX_W  grayscale pixel, unsigned.
- frame_ready  out  1  high while a complete integral image is held in RAM.
- frame_done  out  1  one-cycle pulse when the last pixel's integral value has been written.
- rd_addr  in  ADDR_W  read address: y*II_WIDTH + x.
- rd_data  out  DATA_W  signed integral value for the rd_addr presented 3 cycles earlier.

Behaviour:
- Definition: ii(x,y) = sum of pix(i,j) for all i<=x and j<=y. Address = y*160 + x. Numbering runs left to right, then top to bottom.
- Reset values: frame_ready=0, frame_done=0, rd_data=0, state=IDLE, x=0, y=0, row accumulator=0. RAM and line buffer contents are not cleared.
- States:
  - IDLE: wait for sof&&pix_valid; go to FILL and process that pixel as (0,0).
  - FILL: accumulate pixels.
  - DONE: frame_ready=1; wait for the next sof&&pix_valid.
- FILL arithmetic, per accepted pixel:
  - row_acc_nxt = (x==0 ? 0 : row_acc) + pix. Width 12 bits unsigned; max 2400.
  - ii = row_acc_nxt + (y==0 ? 0 : line_buf[x]).
  - line_buf[x] <= ii, where line_buf is a 160 x DATA_W register/RAM holding the previous row.
  - RAM[y*160+x] <= ii.
  - Writes may be registered; total write latency from pixel acceptance is at most 2 cycles.
- Counters:
  - x increments per accepted pixel.
  - On x==159: x wraps to 0 and y increments.
  - On the pixel at (159,119): state goes to DONE. frame_done pulses for exactly one cycle, in the cycle after the final RAM write completes. frame_ready rises in that same cycle.
- pix_valid low: stall. No counter, accumulator or RAM change; gaps of any length are legal.
- sof&&pix_valid while in FILL (frame restarted mid-frame): discard progress. That pixel becomes (0,0), the block stays in FILL, and no frame_done is issued.
- sof&&pix_valid while in DONE: frame_ready drops to 0 in the next cycle and FILL restarts at (0,0). The detection state machine must not start detection while frame_ready=0.
- pix_valid without sof in IDLE or DONE: ignored.
- Read path, fixed 3-cycle latency, always active regardless of state:
  - Cycle 1: register rd_addr.
  - Cycle 2: synchronous RAM read.
  - Cycle 3: register to rd_data.
  - A new address may be presented every cycle, fully pipelined.
- Out-of-range read (rd_addr >= 19200): rd_data = 0, still with 3-cycle latency. The range check is pipelined alongside the address.
- Simultaneous read and write to the same address: read-first, returning the old contents.
- Reset mid-FILL: the block returns to IDLE, frame_ready=0, and the partial frame is abandoned. Read-pipeline registers are zeroed.
- rd_data is sign-extended in type only; values are always >= 0.

Test Plan:
- Reset then idle:
  - Stimulus: no pixels; read addr 0 after reset.
  - Required: frame_ready=0, frame_done=0, rd_data=0 during reset and in the 3 cycles after.
- Uniform frame of value 1, continuous pix_valid from sof:
  - Required: exactly one frame_done pulse and frame_ready=1.
  - Reads required: addr 0 -> 1, addr 159 -> 160, addr 9760 (row 61, x=0) -> 62, addr 9759 -> 9760, addr 19199 -> 19200.
- Maximum frame, all pixels 15, with random pix_valid gaps:
  - Reads required: addr 19199 -> 288000, addr 159 -> 2400, addr 160 -> 30.
  - No overflow.
- Read latency and pipelining:
  - Stimulus: back-to-back addresses 0, 19199, 19200, 32767 on consecutive cycles.
  - Required: rd_data equals 1, 19200, 0, 0 (uniform-1 frame) on cycles T+3 through T+6.
- Mid-frame restart:
  - Stimulus: after 5000 pixels of value 2, assert sof, then send a full frame of value 1.
  - Required: only one frame_done; addr 19199 -> 19200; addr 0 -> 1.
- Reset mid-frame and new frame after DONE:
  - Stimulus: assert rst at pixel 100.
  - Required: back to IDLE, frame_ready=0; the next full frame completes normally.
  - Stimulus: a new sof in DONE.
  - Required: frame_ready=0 on the following cycle.
